mem_readback: RTL

MEM_READBACK -- requirements
Module: mem_readback

---
 rtl/mem_rb_pkg.sv | 17 +
 rtl/rb_fifo.sv | 47 ++++
 rtl/mem_readback.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_rb_pkg.sv
// Shared types and constants for the memory readback streamer.
package mem_rb_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } rb_state_t;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] last);
        return (a == last) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/rb_fifo.sv
// Two-entry buffer holding words returned by the memory read port.
module rb_fifo #(
    parameter int WID_MEM = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WID_MEM-1:0] din,
    output logic [WID_MEM-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [1:0]         count
);

    logic [WID_MEM-1:0] slot [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = slot[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= '0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= din;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/mem_readback.sv
// Streams len words from a synchronous-read memory, starting at start_addr,
// onto a valid/ready interface with last-beat marking.
module mem_readback
    import mem_rb_pkg::*;
#(
    parameter int WID_MEM   = 16,
    parameter int DEPTH_MEM = 8192
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] raddr,
    input  logic [WID_MEM-1:0] rdata,
    output logic [WID_MEM-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] DEPTH_W   = ADDR_W'(DEPTH_MEM);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);

    rb_state_t         state;
    logic [ADDR_W-1:0] rem_rd;
    logic [ADDR_W-1:0] rem_out;
    logic              rd_pend;
    logic              issue;
    logic              pop;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [2:0]        occ;

    rb_fifo #(
        .WID_MEM(WID_MEM)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (pop),
        .din  (rdata),
        .dout (m_data),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    assign m_valid   = !fifo_empty;
    assign m_last    = m_valid && (rem_out == ADDR_W'(1));
    assign fifo_push = rd_pend && !fifo_full;

    // A read counts as issued at the edge where the memory samples raddr;
    // rd_pend then marks its data arriving on rdata for the following edge.
    always_comb begin
        pop   = m_valid && m_ready;
        occ   = {1'b0, fifo_count} + {2'b0, rd_pend};
        issue = (state == RUN) && (rem_rd != '0) && (occ < (3'd2 + {2'b0, pop}));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            raddr   <= '0;
            rem_rd  <= '0;
            rem_out <= '0;
            rd_pend <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            rd_pend <= issue;
            if (pop) begin
                rem_out <= rem_out - 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (start_addr >= DEPTH_W) begin
                            err <= 1'b1;
                        end else if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            raddr   <= start_addr;
                            rem_rd  <= len;
                            rem_out <= len;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        raddr  <= wrap_inc(raddr, LAST_ADDR);
                        rem_rd <= rem_rd - 1'b1;
                        if (rem_rd == ADDR_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && m_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
